// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: N-channel registered mux with manual select and dwell-timed round-robin scan.
// Define MUX_CH_MASK_EN to add the ch_mask port that skips disabled channels.
module mux_nx1_scan #(
    parameter int N = 4,
    parameter int W = 1,
    parameter int DWELL_W = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
`ifdef MUX_CH_MASK_EN
    input  logic [N-1:0]       ch_mask,
`endif
    input  logic [N*W-1:0]     din,
    output logic [W-1:0]       y,
    output logic [SEL_W-1:0]   ch,
    output logic               valid,
    output logic               wrap
);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [W-1:0]       y_q, y_d;
    logic [SEL_W-1:0]   ch_q, ch_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               valid_q, valid_d, wrap_q, wrap_d, first_q, first_d;
    logic [N-1:0]       mask;
    logic [W-1:0]       chan [N];
    logic [SEL_W-1:0]   sel_c, nxt;
    logic [2*N-1:0]     rot;
    logic               nxt_wrap, found, adv;
    int                 base, k;

`ifdef MUX_CH_MASK_EN
    assign mask = ch_mask;
`else
    assign mask = '1;
`endif

    assign sel_c = (sel > LAST) ? LAST : sel;
    assign adv   = first_q || (cnt_q >= dwell) || !mask[ch_q];

    always_comb begin
        for (int i = 0; i < N; i++) chan[i] = din[i*W +: W];
    end

    // Search the next enabled channel; right after reset the search begins at channel 0 itself.
    always_comb begin
        base = first_q ? 0 : int'(ch_q) + 1;
        rot = {mask, mask} >> base;
        k = 0;
        found = 1'b0;
        nxt = ch_q;
        nxt_wrap = 1'b0;
        for (int i = 0; i < N; i++) begin
            k = base + i;
            if (!found && rot[i]) begin
                found = 1'b1;
                nxt = SEL_W'(k >= N ? k - N : k);
                nxt_wrap = (k >= N);
            end
        end
    end

    always_comb begin
        y_d = y_q;
        ch_d = ch_q;
        cnt_d = cnt_q;
        valid_d = 1'b0;
        wrap_d = 1'b0;
        first_d = first_q;
        if (en) begin
            first_d = 1'b0;
            if (!mode) begin
                ch_d = sel_c;
                cnt_d = '0;
                valid_d = mask[sel_c];
                y_d = mask[sel_c] ? chan[sel_c] : '0;
            end else if (~|mask) begin
                y_d = '0;
            end else if (adv) begin
                ch_d = nxt;
                cnt_d = '0;
                wrap_d = nxt_wrap;
                valid_d = 1'b1;
                y_d = chan[nxt];
            end else begin
                cnt_d = cnt_q + 1'b1;
                valid_d = 1'b1;
                y_d = chan[ch_q];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
            ch_q <= '0;
            cnt_q <= '0;
            valid_q <= 1'b0;
            wrap_q <= 1'b0;
            first_q <= 1'b1;
        end else begin
            y_q <= y_d;
            ch_q <= ch_d;
            cnt_q <= cnt_d;
            valid_q <= valid_d;
            wrap_q <= wrap_d;
            first_q <= first_d;
        end
    end

    assign y = y_q;
    assign ch = ch_q;
    assign valid = valid_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb_mux_nx1_scan: directed scoreboard bench for mux_nx1_scan (N=4, W=8).
module tb_mux_nx1_scan;
    localparam int N = 4, W = 8, DW = 8, SW = 2;

    logic          clk = 0, rst = 1, en = 0, mode = 0;
    logic [SW-1:0] sel = 0;
    logic [DW-1:0] dwell = 0;
    logic [N*W-1:0] din = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    logic [W-1:0]  y;
    logic [SW-1:0] ch;
    logic          valid, wrap;
`ifdef MUX_CH_MASK_EN
    logic [N-1:0]  ch_mask = '1;
`endif

    int checks = 0, errors = 0;
    logic [W+SW:0] q [$];

    mux_nx1_scan #(.N(N), .W(W), .DWELL_W(DW)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
`ifdef MUX_CH_MASK_EN
        .ch_mask(ch_mask),
`endif
        .din(din), .y(y), .ch(ch), .valid(valid), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Monitor: every valid output must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got y=%h ch=%0d wrap=%0d, required no output", y, ch, wrap);
            end else begin
                logic [W+SW:0] e;
                e = q.pop_front();
                if ({y, ch, wrap} !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got y=%h ch=%0d wrap=%0d, required y=%h ch=%0d wrap=%0d",
                             y, ch, wrap, e[W+SW:SW+1], e[SW:1], e[0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic m, input logic [SW-1:0] s, input logic [DW-1:0] d,
                       input logic push, input logic [W-1:0] ey, input logic [SW-1:0] ec, input logic ew);
        en = e; mode = m; sel = s; dwell = d;
        if (push) q.push_back({ey, ec, ew});
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_y", y, 0);
        chk("reset_ch", ch, 0);
        chk("reset_valid", valid, 0);
        chk("reset_wrap", wrap, 0);
        rst = 0;
        // Manual select of each channel
        cyc(1, 0, 0, 0, 1, 8'hAA, 0, 0);
        cyc(1, 0, 1, 0, 1, 8'hBB, 1, 0);
        cyc(1, 0, 2, 0, 1, 8'hCC, 2, 0);
        cyc(1, 0, 3, 0, 1, 8'hDD, 3, 0);
        // Mode switch: manual ch2 -> scan advances to 3 -> manual sel 1
        cyc(1, 0, 2, 0, 1, 8'hCC, 2, 0);
        cyc(1, 1, 0, 0, 1, 8'hDD, 3, 0);
        cyc(1, 0, 1, 0, 1, 8'hBB, 1, 0);
        // Scan dwell=0 from ch0
        cyc(1, 0, 0, 0, 1, 8'hAA, 0, 0);
        cyc(1, 1, 0, 0, 1, 8'hBB, 1, 0);
        cyc(1, 1, 0, 0, 1, 8'hCC, 2, 0);
        cyc(1, 1, 0, 0, 1, 8'hDD, 3, 0);
        cyc(1, 1, 0, 0, 1, 8'hAA, 0, 1);
        cyc(1, 1, 0, 0, 1, 8'hBB, 1, 0);
        // Scan dwell=2: each channel held three en cycles
        cyc(1, 1, 0, 2, 1, 8'hBB, 1, 0);
        cyc(1, 1, 0, 2, 1, 8'hBB, 1, 0);
        cyc(1, 1, 0, 2, 1, 8'hCC, 2, 0);
        cyc(1, 1, 0, 2, 1, 8'hCC, 2, 0);
        cyc(1, 1, 0, 2, 1, 8'hCC, 2, 0);
        cyc(1, 1, 0, 2, 1, 8'hDD, 3, 0);
        cyc(1, 1, 0, 2, 1, 8'hDD, 3, 0);
        // en low mid-dwell freezes everything
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 2, 0, 0, 0, 0);
            chk("gate_valid", valid, 0);
            chk("gate_ch", ch, 3);
            chk("gate_y", y, 8'hDD);
        end
        cyc(1, 1, 0, 2, 1, 8'hDD, 3, 0);
        cyc(1, 1, 0, 2, 1, 8'hAA, 0, 1);
        // Async reset mid-scan at ch2
        cyc(1, 1, 0, 0, 1, 8'hBB, 1, 0);
        cyc(1, 1, 0, 0, 1, 8'hCC, 2, 0);
        #6;
        rst = 1;
        #1;
        chk("async_rst_y", y, 0);
        chk("async_rst_ch", ch, 0);
        chk("async_rst_valid", valid, 0);
        chk("async_rst_wrap", wrap, 0);
        @(negedge clk);
        rst = 0;
        cyc(1, 1, 0, 0, 1, 8'hAA, 0, 0);
        cyc(1, 1, 0, 0, 1, 8'hBB, 1, 0);
`ifdef MUX_CH_MASK_EN
        ch_mask = 4'b1010;
        cyc(1, 1, 0, 0, 1, 8'hDD, 3, 0);
        cyc(1, 1, 0, 0, 1, 8'hBB, 1, 1);
        cyc(1, 1, 0, 0, 1, 8'hDD, 3, 0);
        cyc(1, 1, 0, 0, 1, 8'hBB, 1, 1);
        ch_mask = 4'b0000;
        cyc(1, 1, 0, 0, 0, 0, 0, 0);
        chk("mask0_valid", valid, 0);
        chk("mask0_y", y, 0);
        chk("mask0_ch", ch, 1);
`endif
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
